// File: rtl/dram_slot_arbiter.sv
// dram_slot_arbiter
//   Time-slot arbiter that shares one 16-bit DRAM controller between video fetch,
//   the Z80 and DMA (SD card). Each slot is SLOT_LEN fclk cycles long and carries
//   exactly one access or one refresh. Requests are sampled in the last phase of
//   a slot. The winner is issued at phase 0 of the following slot.
//
// Ports
//   fclk, rst            clock and synchronous active-high reset
//   req/req_rnw          per-requester level request and direction ([0]=video [1]=cpu [2]=dma)
//   req_addr/_wrdata/_bsel  per-requester access fields, packed as slices
//   ack                  one-hot pulse at phase 0: request taken in this slot
//   rdy                  one-hot pulse RD_LAT cycles after dram_req: access complete
//   rd_data              last read data (shows dram_rddata during the rdy cycle of a read)
//   cpu_stall            held for a whole slot in which the cpu asked and lost
//   dram_req/dram_rfsh   phase-0 pulses starting an access or a refresh cycle
//   dram_rnw/addr/wrdata/bsel  access fields, stable for the whole slot
//   dram_rddata          read data from the cycle generator, valid RD_LAT cycles after dram_req
module dram_slot_arbiter #(
  parameter int AW         = 21,
  parameter int SLOT_LEN   = 4,
  parameter int RD_LAT     = 3,
  parameter int STARVE_MAX = 4,
  parameter int RFSH_MAX   = 32
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [2:0]        req_rnw,
  input  logic [3*AW-1:0]   req_addr,
  input  logic [47:0]       req_wrdata,
  input  logic [5:0]        req_bsel,
  output logic [2:0]        ack,
  output logic [2:0]        rdy,
  output logic [15:0]       rd_data,
  output logic              cpu_stall,
  output logic              dram_req,
  output logic              dram_rfsh,
  output logic              dram_rnw,
  output logic [AW-1:0]     dram_addr,
  output logic [15:0]       dram_wrdata,
  output logic [1:0]        dram_bsel,
  input  logic [15:0]       dram_rddata
);

  localparam int PH_W = $clog2(SLOT_LEN);
  localparam int ST_W = $clog2(STARVE_MAX + 1);
  localparam int RF_W = $clog2(RFSH_MAX + 1);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_LEN - 1);
  localparam logic [ST_W-1:0] ST_SAT  = ST_W'(STARVE_MAX);
  localparam logic [RF_W-1:0] RF_SAT  = RF_W'(RFSH_MAX);

  function automatic logic [ST_W-1:0] starve_inc(input logic [ST_W-1:0] v);
    return (v >= ST_SAT) ? ST_SAT : v + ST_W'(1);
  endfunction

  function automatic logic [RF_W-1:0] rfsh_inc(input logic [RF_W-1:0] v);
    return (v >= RF_SAT) ? RF_SAT : v + RF_W'(1);
  endfunction

  logic [PH_W-1:0] phase;
  logic [ST_W-1:0] starve_cnt;
  logic [RF_W-1:0] rfsh_cnt;

  logic            sample;
  logic            force_rfsh;
  logic            dma_hi;
  logic [2:0]      win_sel;
  logic            win_rfsh;
  logic [1:0]      win_idx;
  logic            win_rnw;
  logic [AW-1:0]   win_addr;
  logic [15:0]     win_wrdata;
  logic [1:0]      win_bsel;

  logic [2:0]      inflight_sel_p1 [RD_LAT];
  logic            inflight_rnw_p1 [RD_LAT];
  logic            rd_hit;
  logic [15:0]     rd_data_q;

  // Stage p0: arbitration at the last phase of the slot
  always_comb begin
    sample     = (phase == PH_LAST);
    force_rfsh = (rfsh_cnt >= RF_SAT);
    dma_hi     = (starve_cnt >= ST_SAT);
    win_sel    = 3'b000;
    win_rfsh   = 1'b0;
    if (force_rfsh) begin
      win_rfsh = 1'b1;
    end else if (req[0]) begin
      win_sel = 3'b001;
    end else if (req[2] && dma_hi) begin
      win_sel = 3'b100;
    end else if (req[1]) begin
      win_sel = 3'b010;
    end else if (req[2]) begin
      win_sel = 3'b100;
    end else begin
      win_rfsh = 1'b1;
    end
  end

  always_comb begin
    win_idx = 2'd0;
    if (win_sel[1]) begin
      win_idx = 2'd1;
    end else if (win_sel[2]) begin
      win_idx = 2'd2;
    end
  end

  always_comb begin
    win_rnw    = req_rnw[0];
    win_addr   = req_addr[0 +: AW];
    win_wrdata = req_wrdata[0 +: 16];
    win_bsel   = req_bsel[0 +: 2];
    case (win_idx)
      2'd1: begin
        win_rnw    = req_rnw[1];
        win_addr   = req_addr[AW +: AW];
        win_wrdata = req_wrdata[16 +: 16];
        win_bsel   = req_bsel[2 +: 2];
      end
      2'd2: begin
        win_rnw    = req_rnw[2];
        win_addr   = req_addr[2*AW +: AW];
        win_wrdata = req_wrdata[32 +: 16];
        win_bsel   = req_bsel[4 +: 2];
      end
      default: begin
        win_rnw    = req_rnw[0];
        win_addr   = req_addr[0 +: AW];
        win_wrdata = req_wrdata[0 +: 16];
        win_bsel   = req_bsel[0 +: 2];
      end
    endcase
  end

  // Stage p0 -> phase 0: grant, slot counters and in-flight tracking
  always_ff @(posedge fclk) begin
    if (rst) begin
      phase      <= '0;
      starve_cnt <= '0;
      rfsh_cnt   <= '0;
      ack        <= 3'b000;
      dram_req   <= 1'b0;
      dram_rfsh  <= 1'b0;
      cpu_stall  <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) begin
        inflight_sel_p1[k] <= 3'b000;
      end
    end else begin
      phase     <= sample ? '0 : phase + PH_W'(1);
      ack       <= 3'b000;
      dram_req  <= 1'b0;
      dram_rfsh <= 1'b0;
      if (sample) begin
        ack        <= win_sel;
        dram_req   <= |win_sel;
        dram_rfsh  <= win_rfsh;
        cpu_stall  <= req[1] & ~win_sel[1];
        starve_cnt <= (!req[2] || win_sel[2]) ? '0 : starve_inc(starve_cnt);
        rfsh_cnt   <= win_rfsh ? '0 : rfsh_inc(rfsh_cnt);
      end
      // ack is non-zero only in the dram_req cycle, so it seeds the rdy pipe directly
      inflight_sel_p1[0] <= ack;
      for (int k = 1; k < RD_LAT; k++) begin
        inflight_sel_p1[k] <= inflight_sel_p1[k-1];
      end
    end
  end

  // Stage p0 -> phase 0: access fields, held through refresh slots
  always_ff @(posedge fclk) begin
    if (rst) begin
      dram_rnw    <= 1'b0;
      dram_addr   <= '0;
      dram_wrdata <= 16'h0000;
      dram_bsel   <= 2'b00;
      rd_data_q   <= 16'h0000;
    end else begin
      if (sample && (|win_sel)) begin
        dram_rnw    <= win_rnw;
        dram_addr   <= win_addr;
        dram_wrdata <= win_wrdata;
        dram_bsel   <= win_bsel;
      end
      if (rd_hit) begin
        rd_data_q <= dram_rddata;
      end
    end
  end

  // Stage p1: direction travels with the in-flight one-hot select
  always_ff @(posedge fclk) begin
    inflight_rnw_p1[0] <= dram_rnw;
    for (int k = 1; k < RD_LAT; k++) begin
      inflight_rnw_p1[k] <= inflight_rnw_p1[k-1];
    end
  end

  // Stage p2: completion; read data bypasses the holding register in the rdy cycle
  assign rdy     = inflight_sel_p1[RD_LAT-1];
  assign rd_hit  = (|rdy) & inflight_rnw_p1[RD_LAT-1];
  assign rd_data = rd_hit ? dram_rddata : rd_data_q;

endmodule

// File: tb/tb_dram_slot_arbiter.sv
module tb_dram_slot_arbiter;

  localparam int AW         = 21;
  localparam int SLOT_LEN   = 4;
  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 4;
  localparam int RFSH_MAX   = 32;

  logic              fclk = 1'b0;
  logic              rst;
  logic [2:0]        req;
  logic [2:0]        req_rnw;
  logic [3*AW-1:0]   req_addr;
  logic [47:0]       req_wrdata;
  logic [5:0]        req_bsel;
  logic [2:0]        ack;
  logic [2:0]        rdy;
  logic [15:0]       rd_data;
  logic              cpu_stall;
  logic              dram_req;
  logic              dram_rfsh;
  logic              dram_rnw;
  logic [AW-1:0]     dram_addr;
  logic [15:0]       dram_wrdata;
  logic [1:0]        dram_bsel;
  logic [15:0]       dram_rddata;

  dram_slot_arbiter #(
    .AW(AW), .SLOT_LEN(SLOT_LEN), .RD_LAT(RD_LAT),
    .STARVE_MAX(STARVE_MAX), .RFSH_MAX(RFSH_MAX)
  ) dut (
    .fclk(fclk), .rst(rst), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
    .req_wrdata(req_wrdata), .req_bsel(req_bsel), .ack(ack), .rdy(rdy),
    .rd_data(rd_data), .cpu_stall(cpu_stall), .dram_req(dram_req),
    .dram_rfsh(dram_rfsh), .dram_rnw(dram_rnw), .dram_addr(dram_addr),
    .dram_wrdata(dram_wrdata), .dram_bsel(dram_bsel), .dram_rddata(dram_rddata)
  );

  always #5 fclk = ~fclk;

  typedef struct packed {
    logic          rf;
    logic [2:0]    sel;
    logic          rnw;
    logic [AW-1:0] addr;
    logic [15:0]   wd;
    logic [1:0]    bs;
    logic          stall;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  int m_starve;
  int m_rfsh;
  logic [15:0]   last_rd;
  logic          exp_rnw;
  logic [AW-1:0] exp_addr;
  logic [15:0]   exp_wd;
  logic [1:0]    exp_bs;

  int obs_rfsh;
  int obs_ack [3];
  int obs_stall;

  logic [2:0]    b_rnw;
  logic [AW-1:0] b_addr [3];
  logic [15:0]   b_wd [3];
  logic [1:0]    b_bs [3];

  function automatic logic [15:0] rdval(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  task automatic clear_obs();
    obs_rfsh = 0;
    obs_stall = 0;
    for (int i = 0; i < 3; i++) obs_ack[i] = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = 3'b000;
    @(negedge fclk);
    rst = 1'b0;
    m_starve = 0;
    m_rfsh = 0;
    exp_q.delete();
    last_rd = 16'h0000;
    exp_rnw = 1'b0;
    exp_addr = '0;
    exp_wd = 16'h0000;
    exp_bs = 2'b00;
    clear_obs();
  endtask

  // Entered and left at the negedge of phase 0 of a slot. Checks the slot granted
  // by the previous call, and drives the request that the DUT samples at this slot's end.
  task automatic run_slot(input logic [2:0] r);
    exp_t e;
    exp_t ne;
    logic gnt;
    logic [2:0] sel;
    logic rf;
    int idx;
    logic [2:0] x_ack;
    logic [2:0] x_rdy;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    gnt = (e.sel != 3'b000);
    if (gnt) begin
      exp_rnw = e.rnw;
      exp_addr = e.addr;
      exp_wd = e.wd;
      exp_bs = e.bs;
    end
    for (int p = 0; p < SLOT_LEN; p++) begin
      if (p > 0) @(negedge fclk);
      x_ack = (p == 0) ? e.sel : 3'b000;
      x_rdy = (p == RD_LAT) ? e.sel : 3'b000;
      checks++;
      if (ack !== x_ack) begin
        errors++;
        $display("FAIL ack p=%0d: got %b expected %b", p, ack, x_ack);
      end
      checks++;
      if (dram_req !== (p == 0 && gnt)) begin
        errors++;
        $display("FAIL dram_req p=%0d: got %b expected %b", p, dram_req, (p == 0 && gnt));
      end
      checks++;
      if (dram_rfsh !== (p == 0 && e.rf)) begin
        errors++;
        $display("FAIL dram_rfsh p=%0d: got %b expected %b", p, dram_rfsh, (p == 0 && e.rf));
      end
      checks++;
      if (cpu_stall !== e.stall) begin
        errors++;
        $display("FAIL cpu_stall p=%0d: got %b expected %b", p, cpu_stall, e.stall);
      end
      checks++;
      if (rdy !== x_rdy) begin
        errors++;
        $display("FAIL rdy p=%0d: got %b expected %b", p, rdy, x_rdy);
      end
      checks++;
      if ({dram_rnw, dram_addr, dram_wrdata, dram_bsel} !== {exp_rnw, exp_addr, exp_wd, exp_bs}) begin
        errors++;
        $display("FAIL dram_fields p=%0d: got rnw=%b addr=%h wd=%h bs=%b expected rnw=%b addr=%h wd=%h bs=%b",
                 p, dram_rnw, dram_addr, dram_wrdata, dram_bsel, exp_rnw, exp_addr, exp_wd, exp_bs);
      end
      if (p == RD_LAT && gnt && e.rnw) last_rd = rdval(e.addr);
      checks++;
      if (rd_data !== last_rd) begin
        errors++;
        $display("FAIL rd_data p=%0d: got %h expected %h", p, rd_data, last_rd);
      end
      if (cpu_stall === 1'b1) obs_stall++;
      if (p == 0) begin
        if (dram_rfsh === 1'b1) obs_rfsh++;
        for (int i = 0; i < 3; i++) if (ack[i] === 1'b1) obs_ack[i]++;
        req = r;
        req_rnw = b_rnw;
        for (int i = 0; i < 3; i++) begin
          req_addr[i*AW +: AW] = b_addr[i];
          req_wrdata[i*16 +: 16] = b_wd[i];
          req_bsel[i*2 +: 2] = b_bs[i];
        end
        sel = 3'b000;
        rf = 1'b0;
        if (m_rfsh >= RFSH_MAX) rf = 1'b1;
        else if (r[0]) sel = 3'b001;
        else if (r[2] && m_starve >= STARVE_MAX) sel = 3'b100;
        else if (r[1]) sel = 3'b010;
        else if (r[2]) sel = 3'b100;
        else rf = 1'b1;
        idx = sel[2] ? 2 : (sel[1] ? 1 : 0);
        ne.rf = rf;
        ne.sel = sel;
        ne.rnw = b_rnw[idx];
        ne.addr = b_addr[idx];
        ne.wd = b_wd[idx];
        ne.bs = b_bs[idx];
        ne.stall = r[1] & ~sel[1];
        exp_q.push_back(ne);
        m_starve = (!r[2] || sel[2]) ? 0 : ((m_starve >= STARVE_MAX) ? STARVE_MAX : m_starve + 1);
        m_rfsh = rf ? 0 : ((m_rfsh >= RFSH_MAX) ? RFSH_MAX : m_rfsh + 1);
      end
      if (((p + 1 == RD_LAT) || (p == RD_LAT)) && gnt && e.rnw) dram_rddata = rdval(e.addr);
      else dram_rddata = 16'hBEEF;
    end
    @(negedge fclk);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    repeat (3) @(negedge fclk);
    checks++;
    if ({ack, rdy, rd_data, cpu_stall, dram_req, dram_rfsh, dram_rnw, dram_addr, dram_wrdata, dram_bsel} !== '0) begin
      errors++;
      $display("FAIL reset_state: got ack=%b rdy=%b rd=%h stall=%b req=%b rfsh=%b addr=%h expected all zero",
               ack, rdy, rd_data, cpu_stall, dram_req, dram_rfsh, dram_addr);
    end
    apply_reset();
    b_addr[1] = 21'h00555;
    b_rnw[1] = 1'b1;
    run_slot(3'b010);
    e = exp_q.pop_front();
    checks++;
    if ({ack, dram_req} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_pre_ack: got ack=%b dram_req=%b expected ack=010 dram_req=1", ack, dram_req);
    end
    req = 3'b000;
    @(negedge fclk);
    rst = 1'b1;
    @(negedge fclk);
    checks++;
    if ({ack, rdy, rd_data, cpu_stall, dram_req, dram_rfsh, dram_rnw, dram_addr, dram_wrdata, dram_bsel} !== '0) begin
      errors++;
      $display("FAIL reset_mid_slot: got ack=%b rdy=%b rd=%h stall=%b req=%b rfsh=%b rnw=%b addr=%h expected all zero",
               ack, rdy, rd_data, cpu_stall, dram_req, dram_rfsh, dram_rnw, dram_addr);
    end
    rst = 1'b0;
    m_starve = 0;
    m_rfsh = 0;
    exp_q.delete();
    last_rd = 16'h0000;
    exp_rnw = 1'b0;
    exp_addr = '0;
    exp_wd = 16'h0000;
    exp_bs = 2'b00;
    clear_obs();
    run_slot(3'b000);
    run_slot(3'b010);
    run_slot(3'b000);
    checks++;
    if (obs_ack[1] !== 1) begin
      errors++;
      $display("FAIL reset_restart_acks: got %0d expected 1", obs_ack[1]);
    end
  endtask

  task automatic test_cpu_read();
    apply_reset();
    b_addr[1] = 21'h01234;
    b_rnw[1] = 1'b1;
    b_wd[1] = 16'h1111;
    b_bs[1] = 2'b11;
    run_slot(3'b010);
    run_slot(3'b000);
    checks++;
    if (rd_data !== 16'hD191) begin
      errors++;
      $display("FAIL cpu_read_data: got %h expected d191", rd_data);
    end
    checks++;
    if (obs_ack[1] !== 1) begin
      errors++;
      $display("FAIL cpu_read_ack: got %0d expected 1", obs_ack[1]);
    end
  endtask

  task automatic test_dma_write();
    b_addr[2] = 21'h1F000;
    b_rnw[2] = 1'b0;
    b_wd[2] = 16'hA55A;
    b_bs[2] = 2'b10;
    clear_obs();
    run_slot(3'b100);
    run_slot(3'b000);
    checks++;
    if (rd_data !== 16'hD191) begin
      errors++;
      $display("FAIL dma_write_rd_hold: got %h expected d191", rd_data);
    end
    checks++;
    if (obs_ack[2] !== 1) begin
      errors++;
      $display("FAIL dma_write_ack: got %0d expected 1", obs_ack[2]);
    end
  endtask

  task automatic test_video_cpu();
    apply_reset();
    b_addr[0] = 21'h0A000;
    b_rnw[0] = 1'b1;
    b_addr[1] = 21'h00042;
    b_rnw[1] = 1'b1;
    for (int i = 0; i < 8; i++) run_slot(3'b011);
    run_slot(3'b000);
    checks++;
    if (obs_ack[0] !== 8 || obs_ack[1] !== 0) begin
      errors++;
      $display("FAIL video_cpu_acks: got video=%0d cpu=%0d expected video=8 cpu=0", obs_ack[0], obs_ack[1]);
    end
    checks++;
    if (obs_stall !== 8 * SLOT_LEN) begin
      errors++;
      $display("FAIL video_cpu_stall_cycles: got %0d expected %0d", obs_stall, 8 * SLOT_LEN);
    end
  endtask

  task automatic test_cpu_dma();
    apply_reset();
    b_rnw[1] = 1'b1;
    b_rnw[2] = 1'b0;
    for (int i = 0; i < 10; i++) run_slot(3'b110);
    run_slot(3'b000);
    checks++;
    if (obs_ack[1] !== 8 || obs_ack[2] !== 2) begin
      errors++;
      $display("FAIL cpu_dma_share: got cpu=%0d dma=%0d expected cpu=8 dma=2", obs_ack[1], obs_ack[2]);
    end
  endtask

  task automatic test_starve_clear();
    apply_reset();
    for (int i = 0; i < 3; i++) run_slot(3'b110);
    run_slot(3'b010);
    for (int i = 0; i < 5; i++) run_slot(3'b110);
    run_slot(3'b000);
    checks++;
    if (obs_ack[1] !== 8 || obs_ack[2] !== 1) begin
      errors++;
      $display("FAIL starve_clear: got cpu=%0d dma=%0d expected cpu=8 dma=1", obs_ack[1], obs_ack[2]);
    end
  endtask

  task automatic test_idle_refresh();
    apply_reset();
    for (int i = 0; i < 6; i++) run_slot(3'b000);
    checks++;
    if (obs_rfsh !== 5) begin
      errors++;
      $display("FAIL idle_refresh: got %0d expected 5", obs_rfsh);
    end
  endtask

  task automatic test_forced_refresh();
    apply_reset();
    b_addr[0] = 21'h00100;
    b_rnw[0] = 1'b1;
    for (int i = 0; i < 66; i++) run_slot(3'b001);
    run_slot(3'b000);
    checks++;
    if (obs_rfsh !== 2 || obs_ack[0] !== 64) begin
      errors++;
      $display("FAIL forced_refresh: got rfsh=%0d video=%0d expected rfsh=2 video=64", obs_rfsh, obs_ack[0]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      b_rnw = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        b_addr[i] = AW'($urandom);
        b_wd[i] = 16'($urandom);
        b_bs[i] = 2'($urandom_range(0, 3));
      end
      run_slot(3'($urandom_range(0, 7)));
    end
    run_slot(3'b000);
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    req_rnw = 3'b000;
    req_addr = '0;
    req_wrdata = '0;
    req_bsel = '0;
    dram_rddata = 16'hBEEF;
    b_rnw = 3'b000;
    for (int i = 0; i < 3; i++) begin
      b_addr[i] = '0;
      b_wd[i] = 16'h0000;
      b_bs[i] = 2'b00;
    end
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_video_cpu();
    test_cpu_dma();
    test_starve_clear();
    test_idle_refresh();
    test_forced_refresh();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
